friscv_regfile_wb: RTL and testbench

// Integer ISA register file and write-back stage. Sits directly downstream of the processing unit: it

---
 rtl/friscv_regfile_wb.sv | 137 +++++++++++++
 tb/tb_friscv_regfile_wb.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/friscv_regfile_wb.sv
// Integer register file and write-back stage: per-byte merged rd writes from ctrl and NB_UNIT units, plus a pending-write scoreboard.
// Latency: reads are combinational with no bypass; writes, reservations and reg_error take effect on the next aclk edge.
// Backpressure: none; every write, reservation and read is accepted in the cycle it is presented.
//
// Ports:
//   aclk, aresetn (async, active low), srst (sync, active high)
//   ctrl_rs1/rs2_addr -> ctrl_rs1/rs2_val : controller read ports
//   ctrl_rd_wr/addr/val                   : controller full-word write (highest priority)
//   ctrl_rsv_valid/addr                   : reserve rd at dispatch, sets reg_pending
//   proc_rs1/rs2_addr -> proc_rs1/rs2_val : per-unit read ports, unit u in slice u
//   proc_rd_wr/addr/val/strb              : per-unit byte-strobed writes (lower unit index wins)
//   reg_pending                           : bit i set while a write to xi is outstanding
//   reg_error                             : RV32E only, one-cycle flag for any access to x16..x31
module friscv_regfile_wb #(
    parameter int XLEN    = 32,
    parameter int RV32E   = 0,
    parameter int NB_UNIT = 2
)(
    input  logic                      aclk,
    input  logic                      aresetn,
    input  logic                      srst,
    input  logic [4:0]                ctrl_rs1_addr,
    output logic [XLEN-1:0]           ctrl_rs1_val,
    input  logic [4:0]                ctrl_rs2_addr,
    output logic [XLEN-1:0]           ctrl_rs2_val,
    input  logic                      ctrl_rd_wr,
    input  logic [4:0]                ctrl_rd_addr,
    input  logic [XLEN-1:0]           ctrl_rd_val,
    input  logic                      ctrl_rsv_valid,
    input  logic [4:0]                ctrl_rsv_addr,
    input  logic [NB_UNIT*5-1:0]      proc_rs1_addr,
    output logic [NB_UNIT*XLEN-1:0]   proc_rs1_val,
    input  logic [NB_UNIT*5-1:0]      proc_rs2_addr,
    output logic [NB_UNIT*XLEN-1:0]   proc_rs2_val,
    input  logic [NB_UNIT-1:0]        proc_rd_wr,
    input  logic [NB_UNIT*5-1:0]      proc_rd_addr,
    input  logic [NB_UNIT*XLEN-1:0]   proc_rd_val,
    input  logic [NB_UNIT*XLEN/8-1:0] proc_rd_strb,
    output logic [31:0]               reg_pending,
    output logic                      reg_error
);

    localparam int NREG  = (RV32E != 0) ? 16 : 32;
    localparam int AW    = (RV32E != 0) ? 4 : 5;
    localparam int NBYTE = XLEN / 8;

    logic [XLEN-1:0] r_regs     [NREG];
    logic [XLEN-1:0] w_regs_nxt [NREG];
    logic [NREG-1:0] r_pend;
    logic [NREG-1:0] w_set;
    logic [NREG-1:0] w_clr;
    logic            r_error;
    logic            w_error;

    // Next register contents. Writers are applied lowest priority first so
    // that each byte ends up holding the value of its highest-priority writer.
    // Index 0 is never touched, which drops every write to x0. Addresses
    // beyond NREG never match an index, which drops x16..x31 under RV32E.
    always_comb begin
        w_regs_nxt = r_regs;
        w_set      = '0;
        w_clr      = '0;
        for (int i = 1; i < NREG; i++) begin
            for (int u = NB_UNIT - 1; u >= 0; u--) begin
                if (proc_rd_wr[u] && proc_rd_addr[u*5 +: 5] == 5'(i)) begin
                    // Any unit write retires the reservation, even with no strobe set.
                    w_clr[i] = 1'b1;
                    for (int k = 0; k < NBYTE; k++) begin
                        if (proc_rd_strb[u*NBYTE + k])
                            w_regs_nxt[i][k*8 +: 8] = proc_rd_val[u*XLEN + k*8 +: 8];
                    end
                end
            end
            if (ctrl_rd_wr && ctrl_rd_addr == 5'(i)) begin
                w_regs_nxt[i] = ctrl_rd_val;
                w_clr[i]      = 1'b1;
            end
            if (ctrl_rsv_valid && ctrl_rsv_addr == 5'(i))
                w_set[i] = 1'b1;
        end
    end

    // Any enabled access to the upper half of the register space is illegal under RV32E.
    // Bit 4 set already implies a nonzero address.
    always_comb begin
        w_error = 1'b0;
        if (RV32E != 0) begin
            w_error = ctrl_rs1_addr[4] | ctrl_rs2_addr[4]
                    | (ctrl_rd_wr & ctrl_rd_addr[4])
                    | (ctrl_rsv_valid & ctrl_rsv_addr[4]);
            for (int u = 0; u < NB_UNIT; u++) begin
                w_error = w_error | proc_rs1_addr[u*5 + 4] | proc_rs2_addr[u*5 + 4]
                        | (proc_rd_wr[u] & proc_rd_addr[u*5 + 4]);
            end
        end
    end

    function automatic logic [XLEN-1:0] f_read(input logic [4:0] addr);
        logic [AW-1:0] idx;
        idx = addr[AW-1:0];
        if (addr == 5'd0 || (RV32E != 0 && addr[4]))
            return '0;
        return r_regs[idx];
    endfunction

    always_comb begin
        proc_rs1_val = '0;
        proc_rs2_val = '0;
        ctrl_rs1_val = f_read(ctrl_rs1_addr);
        ctrl_rs2_val = f_read(ctrl_rs2_addr);
        for (int u = 0; u < NB_UNIT; u++) begin
            proc_rs1_val[u*XLEN +: XLEN] = f_read(proc_rs1_addr[u*5 +: 5]);
            proc_rs2_val[u*XLEN +: XLEN] = f_read(proc_rs2_addr[u*5 +: 5]);
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
            r_pend  <= '0;
            r_error <= 1'b0;
        end else if (srst) begin
            for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
            r_pend  <= '0;
            r_error <= 1'b0;
        end else begin
            r_regs  <= w_regs_nxt;
            // A reservation arriving with a retiring write is younger, so set wins.
            r_pend  <= (r_pend & ~w_clr) | w_set;
            r_error <= w_error;
        end
    end

    assign reg_pending = 32'(r_pend);
    assign reg_error   = r_error;

endmodule

// File: tb/tb_friscv_regfile_wb.sv
module tb_friscv_regfile_wb;

    localparam int K_RD    = 0;  // full config: all read ports at addr
    localparam int K_PEND  = 1;  // full config: reg_pending
    localparam int K_ERR   = 2;  // full config: reg_error
    localparam int K_ERD   = 3;  // RV32E config: ctrl_rs1 at addr
    localparam int K_EERR  = 4;  // RV32E config: reg_error
    localparam int K_EPEND = 5;  // RV32E config: reg_pending

    logic        aclk = 1'b0;
    logic        aresetn, srst;
    logic [4:0]  ctrl_rs1_addr, ctrl_rs2_addr, ctrl_rd_addr, ctrl_rsv_addr;
    logic        ctrl_rd_wr, ctrl_rsv_valid;
    logic [31:0] ctrl_rd_val;
    logic [9:0]  proc_rs1_addr, proc_rs2_addr, proc_rd_addr;
    logic [1:0]  proc_rd_wr;
    logic [63:0] proc_rd_val;
    logic [7:0]  proc_rd_strb;

    logic [31:0] ctrl_rs1_val, ctrl_rs2_val, reg_pending;
    logic [63:0] proc_rs1_val, proc_rs2_val;
    logic        reg_error;
    logic [31:0] e_ctrl_rs1_val, e_ctrl_rs2_val, e_reg_pending;
    logic [63:0] e_proc_rs1_val, e_proc_rs2_val;
    logic        e_reg_error;

    always #5 aclk = ~aclk;

    friscv_regfile_wb #(.XLEN(32), .RV32E(0), .NB_UNIT(2)) dut (
        .aclk(aclk), .aresetn(aresetn), .srst(srst),
        .ctrl_rs1_addr(ctrl_rs1_addr), .ctrl_rs1_val(ctrl_rs1_val),
        .ctrl_rs2_addr(ctrl_rs2_addr), .ctrl_rs2_val(ctrl_rs2_val),
        .ctrl_rd_wr(ctrl_rd_wr), .ctrl_rd_addr(ctrl_rd_addr), .ctrl_rd_val(ctrl_rd_val),
        .ctrl_rsv_valid(ctrl_rsv_valid), .ctrl_rsv_addr(ctrl_rsv_addr),
        .proc_rs1_addr(proc_rs1_addr), .proc_rs1_val(proc_rs1_val),
        .proc_rs2_addr(proc_rs2_addr), .proc_rs2_val(proc_rs2_val),
        .proc_rd_wr(proc_rd_wr), .proc_rd_addr(proc_rd_addr),
        .proc_rd_val(proc_rd_val), .proc_rd_strb(proc_rd_strb),
        .reg_pending(reg_pending), .reg_error(reg_error)
    );

    friscv_regfile_wb #(.XLEN(32), .RV32E(1), .NB_UNIT(2)) dut_e (
        .aclk(aclk), .aresetn(aresetn), .srst(srst),
        .ctrl_rs1_addr(ctrl_rs1_addr), .ctrl_rs1_val(e_ctrl_rs1_val),
        .ctrl_rs2_addr(ctrl_rs2_addr), .ctrl_rs2_val(e_ctrl_rs2_val),
        .ctrl_rd_wr(ctrl_rd_wr), .ctrl_rd_addr(ctrl_rd_addr), .ctrl_rd_val(ctrl_rd_val),
        .ctrl_rsv_valid(ctrl_rsv_valid), .ctrl_rsv_addr(ctrl_rsv_addr),
        .proc_rs1_addr(proc_rs1_addr), .proc_rs1_val(e_proc_rs1_val),
        .proc_rs2_addr(proc_rs2_addr), .proc_rs2_val(e_proc_rs2_val),
        .proc_rd_wr(proc_rd_wr), .proc_rd_addr(proc_rd_addr),
        .proc_rd_val(proc_rd_val), .proc_rd_strb(proc_rd_strb),
        .reg_pending(e_reg_pending), .reg_error(e_reg_error)
    );

    typedef struct {
        logic        cw;  logic [4:0] ca;  logic [31:0] cv;
        logic        rsv; logic [4:0] ra;
        logic [1:0]  pw;
        logic [4:0]  pa0; logic [31:0] pv0; logic [3:0] ps0;
        logic [4:0]  pa1; logic [31:0] pv1; logic [3:0] ps1;
        logic        sr;
        logic [4:0]  chk_a; logic [31:0] chk_v; logic [31:0] pend;
    } vec_t;

    typedef struct {
        int          kind;
        logic [4:0]  addr;
        logic [31:0] exp;
        string       name;
    } sb_t;

    sb_t  sb_q[$];
    vec_t vecs[16];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push(input int k, input logic [4:0] a, input logic [31:0] v, input string n);
        sb_t e;
        e.kind = k; e.addr = a; e.exp = v; e.name = n;
        sb_q.push_back(e);
    endtask

    task automatic set_rd_addr(input logic [4:0] a);
        ctrl_rs1_addr = a; ctrl_rs2_addr = a;
        proc_rs1_addr = {a, a}; proc_rs2_addr = {a, a};
    endtask

    task automatic clear_drive();
        srst = 1'b0;
        ctrl_rd_wr = 1'b0; ctrl_rd_addr = '0; ctrl_rd_val = '0;
        ctrl_rsv_valid = 1'b0; ctrl_rsv_addr = '0;
        proc_rd_wr = '0; proc_rd_addr = '0; proc_rd_val = '0; proc_rd_strb = '0;
        set_rd_addr(5'd0);
    endtask

    task automatic apply(input vec_t v);
        ctrl_rd_wr = v.cw; ctrl_rd_addr = v.ca; ctrl_rd_val = v.cv;
        ctrl_rsv_valid = v.rsv; ctrl_rsv_addr = v.ra;
        proc_rd_wr = v.pw;
        proc_rd_addr = {v.pa1, v.pa0};
        proc_rd_val  = {v.pv1, v.pv0};
        proc_rd_strb = {v.ps1, v.ps0};
        srst = v.sr;
    endtask

    // Clock edge, then drop the drive and pop every expectation queued for this edge.
    task automatic step();
        sb_t e;
        @(posedge aclk);
        #1;
        clear_drive();
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            case (e.kind)
                K_RD: begin
                    set_rd_addr(e.addr);
                    #1;
                    chk(e.name, {ctrl_rs1_val, ctrl_rs2_val, proc_rs1_val, proc_rs2_val}, {6{e.exp}});
                end
                K_PEND:  chk(e.name, 192'(reg_pending), 192'(e.exp));
                K_ERR:   chk(e.name, 192'(reg_error), 192'(e.exp));
                K_ERD: begin
                    set_rd_addr(e.addr);
                    #1;
                    chk(e.name, 192'(e_ctrl_rs1_val), 192'(e.exp));
                end
                K_EERR:  chk(e.name, 192'(e_reg_error), 192'(e.exp));
                default: chk(e.name, 192'(e_reg_pending), 192'(e.exp));
            endcase
        end
        set_rd_addr(5'd0);
    endtask

    initial begin
        //          cw    ca     cv              rsv   ra      pw     pa0    pv0             ps0      pa1    pv1             ps1      sr    chk_a  chk_v           pend
        vecs[0]  = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 5'd0,  2'b00, 5'd0,  32'h0,          4'h0,  5'd0,  32'h0,          4'h0,  1'b0, 5'd5,  32'hDEADBEEF, 32'h0};
        vecs[1]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd9,  2'b00, 5'd0,  32'h0,          4'h0,  5'd0,  32'h0,          4'h0,  1'b0, 5'd5,  32'hDEADBEEF, 32'h0000_0200};
        vecs[2]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd10, 2'b00, 5'd0,  32'h0,          4'h0,  5'd0,  32'h0,          4'h0,  1'b1, 5'd5,  32'h0,        32'h0};
        vecs[3]  = '{1'b1, 5'd0,  32'h1234,     1'b1, 5'd0,  2'b01, 5'd0,  32'hFFFFFFFF,   4'hF,  5'd0,  32'h0,          4'h0,  1'b0, 5'd0,  32'h0,        32'h0};
        vecs[4]  = '{1'b1, 5'd3,  32'h11223344, 1'b0, 5'd0,  2'b00, 5'd0,  32'h0,          4'h0,  5'd0,  32'h0,          4'h0,  1'b0, 5'd3,  32'h11223344, 32'h0};
        vecs[5]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  2'b10, 5'd0,  32'h0,          4'h0,  5'd3,  32'hAABBCCDD,   4'h5,  1'b0, 5'd3,  32'h11BB33DD, 32'h0};
        vecs[6]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  2'b11, 5'd7,  32'h1,          4'hF,  5'd7,  32'h2,          4'hF,  1'b0, 5'd7,  32'h1,        32'h0};
        vecs[7]  = '{1'b1, 5'd7,  32'h3,        1'b0, 5'd0,  2'b11, 5'd7,  32'h1,          4'hF,  5'd7,  32'h2,          4'hF,  1'b0, 5'd7,  32'h3,        32'h0};
        vecs[8]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  2'b11, 5'd8,  32'hAAAAAAAA,   4'h3,  5'd8,  32'h55555555,   4'hF,  1'b0, 5'd8,  32'h5555AAAA, 32'h0};
        vecs[9]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd9,  2'b00, 5'd0,  32'h0,          4'h0,  5'd0,  32'h0,          4'h0,  1'b0, 5'd8,  32'h5555AAAA, 32'h0000_0200};
        vecs[10] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  2'b01, 5'd9,  32'h99,         4'hF,  5'd0,  32'h0,          4'h0,  1'b0, 5'd9,  32'h99,       32'h0};
        vecs[11] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd9,  2'b10, 5'd0,  32'h0,          4'h0,  5'd9,  32'h77,         4'h0,  1'b0, 5'd9,  32'h99,       32'h0000_0200};
        vecs[12] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd20, 2'b00, 5'd0,  32'h0,          4'h0,  5'd0,  32'h0,          4'h0,  1'b0, 5'd9,  32'h99,       32'h0010_0200};
        vecs[13] = '{1'b1, 5'd20, 32'h55,       1'b0, 5'd0,  2'b01, 5'd2,  32'h22,         4'hF,  5'd0,  32'h0,          4'h0,  1'b0, 5'd20, 32'h55,       32'h0000_0200};
        vecs[14] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  2'b10, 5'd0,  32'h0,          4'h0,  5'd9,  32'h0,          4'h0,  1'b0, 5'd2,  32'h22,       32'h0};
        vecs[15] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  2'b00, 5'd0,  32'h0,          4'h0,  5'd0,  32'h0,          4'h0,  1'b0, 5'd9,  32'h99,       32'h0};

        clear_drive();
        aresetn = 1'b0;
        set_rd_addr(5'd5);
        #1;
        chk("rst_read_x5", {ctrl_rs1_val, ctrl_rs2_val, proc_rs1_val, proc_rs2_val}, 192'h0);
        chk("rst_pending", 192'(reg_pending), 192'h0);
        chk("rst_error", 192'(reg_error), 192'h0);
        chk("rst_e_pending", 192'(e_reg_pending), 192'h0);
        chk("rst_e_error", 192'(e_reg_error), 192'h0);
        set_rd_addr(5'd0);
        #11 aresetn = 1'b1;

        for (int i = 0; i < 16; i++) begin
            apply(vecs[i]);
            push(K_RD, vecs[i].chk_a, vecs[i].chk_v, $sformatf("v%0d_reg_x%0d", i, vecs[i].chk_a));
            push(K_PEND, 5'd0, vecs[i].pend, $sformatf("v%0d_pending", i));
            if (i == 13) push(K_ERR, 5'd0, 32'h0, "v13_full_error_stays_low");
            step();
        end

        // A write must not be visible on the read ports in its own cycle.
        ctrl_rd_wr = 1'b1; ctrl_rd_addr = 5'd12; ctrl_rd_val = 32'hCAFE;
        ctrl_rs1_addr = 5'd12;
        #1;
        chk("no_bypass_x12", 192'(ctrl_rs1_val), 192'h0);
        ctrl_rs1_addr = 5'd0;
        push(K_RD, 5'd12, 32'hCAFE, "x12_after_write");
        step();

        // Asynchronous reset between edges clears the array immediately.
        aresetn = 1'b0;
        ctrl_rs1_addr = 5'd12;
        #1;
        chk("async_rst_x12", 192'(ctrl_rs1_val), 192'h0);
        ctrl_rs1_addr = 5'd0;
        aresetn = 1'b1;

        // RV32E: illegal write dropped and flagged for one cycle, legal write commits.
        ctrl_rd_wr = 1'b1; ctrl_rd_addr = 5'd20; ctrl_rd_val = 32'h55;
        proc_rd_wr = 2'b01; proc_rd_addr = {5'd0, 5'd4}; proc_rd_val = {32'h0, 32'h44}; proc_rd_strb = 8'h0F;
        push(K_EERR, 5'd0, 32'h1, "e_err_on_x20_write");
        push(K_ERD, 5'd4, 32'h44, "e_x4_legal_write");
        push(K_EPEND, 5'd0, 32'h0, "e_pending_after_write");
        push(K_ERR, 5'd0, 32'h0, "full_err_on_x20_write");
        step();
        push(K_EERR, 5'd0, 32'h0, "e_err_one_cycle");
        push(K_ERD, 5'd4, 32'h44, "e_x4_holds");
        step();

        ctrl_rs1_addr = 5'd20;
        #1;
        chk("e_read_x20_zero", 192'(e_ctrl_rs1_val), 192'h0);
        chk("full_read_x20", 192'(ctrl_rs1_val), 192'h55);
        push(K_EERR, 5'd0, 32'h1, "e_err_on_x20_read");
        step();

        ctrl_rsv_valid = 1'b1; ctrl_rsv_addr = 5'd20;
        push(K_EPEND, 5'd0, 32'h0, "e_rsv_x20_dropped");
        push(K_EERR, 5'd0, 32'h1, "e_err_on_x20_rsv");
        push(K_PEND, 5'd0, 32'h0010_0000, "full_rsv_x20");
        step();
        push(K_EERR, 5'd0, 32'h0, "e_err_clears");
        push(K_PEND, 5'd0, 32'h0010_0000, "full_pending_holds");
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
